// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing the single L2 request port between the L1 I- and D-miss paths.
// Optional statistics counters are enabled by defining L2_ARB_STATS_EN.
module l2_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_valid_i,
    input  logic              i_rw_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [LINE_W-1:0] i_wdata_i,
    output logic [LINE_W-1:0] i_rdata_o,
    output logic              i_ready_o,
    input  logic              d_valid_i,
    input  logic              d_rw_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    output logic [LINE_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              l2_valid_o,
    output logic              l2_rw_o,
    output logic [ADDR_W-1:0] l2_addr_o,
    output logic [LINE_W-1:0] l2_wdata_o,
    input  logic [LINE_W-1:0] l2_rdata_i,
    input  logic              l2_ready_i,
    output logic [1:0]        grant_o,
    output logic [CNT_W-1:0]  no_grant_i_o,
    output logic [CNT_W-1:0]  no_grant_d_o,
    output logic [CNT_W-1:0]  no_conflict_o,
    output logic [1:0]        state_o
);

    // Handshake: an L1 holds valid (and payload) until its ready pulses; ready is a
    // single-cycle completion mirroring l2_ready_i for the granted side only.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_d;
    logic   grant_i, grant_d;

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        i_ready_o = 1'b0;
        d_ready_o = 1'b0;
        case (state)
            IDLE: begin
                // I wins a tie only when D owned the previous grant.
                if (i_valid_i && (!d_valid_i || last_d)) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end else if (d_valid_i) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end
            end
            BUSY_I: begin
                if (l2_ready_i) begin
                    i_ready_o = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY_D: begin
                if (l2_ready_i) begin
                    d_ready_o = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_d     <= 1'b1;
            l2_rw_o    <= 1'b0;
            l2_addr_o  <= '0;
            l2_wdata_o <= '0;
        end else begin
            state <= state_nxt;
            if (grant_i) begin
                last_d     <= 1'b0;
                l2_rw_o    <= i_rw_i;
                l2_addr_o  <= i_addr_i;
                l2_wdata_o <= i_wdata_i;
            end else if (grant_d) begin
                last_d     <= 1'b1;
                l2_rw_o    <= d_rw_i;
                l2_addr_o  <= d_addr_i;
                l2_wdata_o <= d_wdata_i;
            end
        end
    end

    assign l2_valid_o = (state != IDLE);
    assign grant_o    = {state == BUSY_D, state == BUSY_I};
    assign i_rdata_o  = l2_rdata_i;
    assign d_rdata_o  = l2_rdata_i;
    assign state_o    = state;

`ifdef L2_ARB_STATS_EN
    logic conflict;
    assign conflict = (state == IDLE) && i_valid_i && d_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            no_grant_i_o  <= '0;
            no_grant_d_o  <= '0;
            no_conflict_o <= '0;
        end else begin
            if (grant_i)  no_grant_i_o  <= no_grant_i_o + 1'b1;
            if (grant_d)  no_grant_d_o  <= no_grant_d_o + 1'b1;
            if (conflict) no_conflict_o <= no_conflict_o + 1'b1;
        end
    end
`else
    assign no_grant_i_o  = '0;
    assign no_grant_d_o  = '0;
    assign no_conflict_o = '0;
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter: reset, single grant, alternation, payload hold,
// idle stray ready, mid-transaction reset and statistics counters.
module tb_l2_req_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid, i_rw, d_valid, d_rw;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic              i_ready, d_ready;
    logic              l2_valid, l2_rw, l2_ready;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata, l2_rdata;
    logic [1:0]        grant, state;
    logic [CNT_W-1:0]  cnt_gi, cnt_gd, cnt_conf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_req_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_valid_i(i_valid), .i_rw_i(i_rw), .i_addr_i(i_addr), .i_wdata_i(i_wdata),
        .i_rdata_o(i_rdata), .i_ready_o(i_ready),
        .d_valid_i(d_valid), .d_rw_i(d_rw), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata), .d_ready_o(d_ready),
        .l2_valid_o(l2_valid), .l2_rw_o(l2_rw), .l2_addr_o(l2_addr), .l2_wdata_o(l2_wdata),
        .l2_rdata_i(l2_rdata), .l2_ready_i(l2_ready),
        .grant_o(grant), .no_grant_i_o(cnt_gi), .no_grant_d_o(cnt_gd),
        .no_conflict_o(cnt_conf), .state_o(state)
    );

    // Advance one cycle; inputs are then driven at +1 and outputs checked at +2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 0; i_rw = 0; i_addr = '0; i_wdata = '0;
        d_valid = 0; d_rw = 0; d_addr = '0; d_wdata = '0;
        l2_ready = 0; l2_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (l2_valid !== 1'b0 || grant !== 2'b00 || l2_rw !== 1'b0 || l2_addr !== '0 ||
            l2_wdata !== '0 || i_ready !== 1'b0 || d_ready !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b grant=%b rw=%b addr=%h state=%0d required 0/00/0/0/IDLE",
                     l2_valid, grant, l2_rw, l2_addr, state);
        end
        checks++;
        if (cnt_gi !== 0 || cnt_gd !== 0 || cnt_conf !== 0) begin
            errors++;
            $display("FAIL reset_counters: gi=%0d gd=%0d conf=%0d required 0 0 0", cnt_gi, cnt_gd, cnt_conf);
        end
    endtask

    task automatic test_single_read();
        i_valid = 1; i_rw = 0; i_addr = 32'h0000_1000;
        #1;
        checks++;
        if (l2_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_grant: l2_valid=%b required 0", l2_valid);
        end
        tick();
        #1;
        checks++;
        if (l2_valid !== 1'b1 || l2_addr !== 32'h1000 || grant !== 2'b01 || l2_rw !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: valid=%b addr=%h grant=%b rw=%b required 1 1000 01 0",
                     l2_valid, l2_addr, grant, l2_rw);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            checks++;
            if (i_ready !== 1'b0 || l2_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_wait: cyc=%0d i_ready=%b l2_valid=%b required 0 1", k, i_ready, l2_valid);
            end
        end
        tick();
        l2_ready = 1; l2_rdata = {16{8'hA5}};
        #1;
        checks++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== {16{8'hA5}}) begin
            errors++;
            $display("FAIL single_complete: i_ready=%b d_ready=%b i_rdata=%h required 1 0 a5..a5",
                     i_ready, d_ready, i_rdata);
        end
        tick();
        l2_ready = 0; i_valid = 0;
        #1;
        checks++;
        if (l2_valid !== 1'b0 || grant !== 2'b00 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_release: valid=%b grant=%b i_ready=%b required 0 00 0", l2_valid, grant, i_ready);
        end
    endtask

    // One transaction already granted: check owner/address, complete it, release.
    task automatic finish_txn(input logic [1:0] exp_grant, input logic [ADDR_W-1:0] exp_addr,
                              input int idx);
        checks++;
        if (grant !== exp_grant || l2_addr !== exp_addr) begin
            errors++;
            $display("FAIL alt_grant%0d: grant=%b addr=%h required %b %h", idx, grant, l2_addr, exp_grant, exp_addr);
        end
        tick();
        l2_ready = 1; l2_rdata = {4{32'hC0DE_0000 + idx}};
        #1;
        checks++;
        if (i_ready !== exp_grant[0] || d_ready !== exp_grant[1] || d_rdata !== {4{32'hC0DE_0000 + idx}}) begin
            errors++;
            $display("FAIL alt_ready%0d: i_ready=%b d_ready=%b required %b %b", idx, i_ready, d_ready,
                     exp_grant[0], exp_grant[1]);
        end
    endtask

    task automatic test_alternation();
        do_reset();
        i_valid = 1; i_addr = 32'h100; d_valid = 1; d_addr = 32'h200;
        tick();
        #1;
        finish_txn(2'b01, 32'h100, 0);
        tick();
        l2_ready = 0; i_valid = 0;
        #1;
        checks++;
        if (grant !== 2'b00 || l2_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_idle_gap: grant=%b valid=%b required 00 0", grant, l2_valid);
        end
        tick();
        #1;
        finish_txn(2'b10, 32'h200, 1);
        tick();
        l2_ready = 0; i_valid = 1; i_addr = 32'h300; d_addr = 32'h400;
        tick();
        #1;
        finish_txn(2'b01, 32'h300, 2);
        tick();
        l2_ready = 0; i_valid = 0;
        tick();
        #1;
        finish_txn(2'b10, 32'h400, 3);
        tick();
        l2_ready = 0; d_valid = 0;
    endtask

    task automatic test_stats();
        int exp_gi, exp_gd, exp_conf;
`ifdef L2_ARB_STATS_EN
        exp_gi = 2; exp_gd = 2; exp_conf = 2;
`else
        exp_gi = 0; exp_gd = 0; exp_conf = 0;
`endif
        #1;
        checks++;
        if (cnt_gi !== CNT_W'(exp_gi) || cnt_gd !== CNT_W'(exp_gd) || cnt_conf !== CNT_W'(exp_conf)) begin
            errors++;
            $display("FAIL stats: gi=%0d gd=%0d conf=%0d required %0d %0d %0d",
                     cnt_gi, cnt_gd, cnt_conf, exp_gi, exp_gd, exp_conf);
        end
    endtask

    task automatic test_payload_hold();
        d_valid = 1; d_rw = 1; d_addr = 32'h2000; d_wdata = {4{32'h1234_5678}};
        tick();
        #1;
        checks++;
        if (grant !== 2'b10 || l2_addr !== 32'h2000 || l2_rw !== 1'b1 || l2_wdata !== {4{32'h1234_5678}}) begin
            errors++;
            $display("FAIL hold_grant: grant=%b addr=%h rw=%b wdata=%h required 10 2000 1 12345678..",
                     grant, l2_addr, l2_rw, l2_wdata);
        end
        d_addr = 32'h3000; d_rw = 0; d_wdata = {4{32'hDEAD_BEEF}};
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            checks++;
            if (l2_addr !== 32'h2000 || l2_rw !== 1'b1 || l2_wdata !== {4{32'h1234_5678}}) begin
                errors++;
                $display("FAIL hold_busy%0d: addr=%h rw=%b required 2000 1", k, l2_addr, l2_rw);
            end
        end
        l2_ready = 1;
        #1;
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0 || l2_addr !== 32'h2000) begin
            errors++;
            $display("FAIL hold_complete: d_ready=%b i_ready=%b addr=%h required 1 0 2000", d_ready, i_ready, l2_addr);
        end
        tick();
        l2_ready = 0; d_valid = 0;
        #1;
        checks++;
        if (l2_valid !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL hold_release: valid=%b grant=%b required 0 00", l2_valid, grant);
        end
    endtask

    task automatic test_idle_ready();
        tick();
        l2_ready = 1;
        #1;
        checks++;
        if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready_fwd: i_ready=%b d_ready=%b required 0 0", i_ready, d_ready);
        end
        tick();
        l2_ready = 0;
        #1;
        checks++;
        if (state !== 2'd0 || l2_valid !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL idle_ready_state: state=%0d valid=%b grant=%b required 0 0 00", state, l2_valid, grant);
        end
    endtask

    task automatic test_reset_busy();
        d_valid = 1; d_rw = 0; d_addr = 32'h5000;
        tick();
        #1;
        checks++;
        if (grant !== 2'b10 || l2_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstbusy_grant: grant=%b valid=%b required 10 1", grant, l2_valid);
        end
        rst = 1;
        tick();
        rst = 0; d_valid = 0;
        #1;
        checks++;
        if (l2_valid !== 1'b0 || grant !== 2'b00 || l2_addr !== '0) begin
            errors++;
            $display("FAIL rstbusy_clear: valid=%b grant=%b addr=%h required 0 00 0", l2_valid, grant, l2_addr);
        end
        l2_ready = 1;
        #1;
        checks++;
        if (d_ready !== 1'b0 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstbusy_stray: d_ready=%b i_ready=%b required 0 0", d_ready, i_ready);
        end
        tick();
        l2_ready = 0;
        #1;
        checks++;
        if (state !== 2'd0 || l2_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstbusy_idle: state=%0d valid=%b required 0 0", state, l2_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternation();
        test_stats();
        test_payload_hold();
        test_idle_ready();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
